// File: rtl/vga_object_compositor_if.sv
// Object update port: valid/ready handshake carrying one object's centre, colour and enable.
interface vga_object_compositor_if #(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned COORD_W = 12
);
    // One spare index code so out-of-range writes are representable on the bus
    localparam int unsigned IDX_W = $clog2(NUM_OBJ + 1);

    logic                      upd_valid;
    logic                      upd_ready;
    logic [IDX_W-1:0]          upd_index;
    logic signed [COORD_W-1:0] upd_x;
    logic signed [COORD_W-1:0] upd_y;
    logic [23:0]               upd_color;
    logic                      upd_enable;

    modport master (
        output upd_valid, upd_index, upd_x, upd_y, upd_color, upd_enable,
        input  upd_ready
    );
    modport slave (
        input  upd_valid, upd_index, upd_x, upd_y, upd_color, upd_enable,
        output upd_ready
    );
endinterface

// File: rtl/vga_object_compositor.sv
// Composites NUM_OBJ rectangular markers over a background pixel stream; object
// updates land in shadow registers and commit together on the vsync falling edge.
module vga_object_compositor #(
    parameter int unsigned NUM_OBJ      = 4,
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned OBJ_W        = 16,
    parameter int unsigned OBJ_H        = 16,
    parameter int unsigned TOTAL_WIDTH  = 1024,
    parameter int unsigned TOTAL_HEIGHT = 768,
    parameter int unsigned Y_OFFSET     = 256,
    parameter int unsigned ALPHA_M      = 2,
    parameter int unsigned ALPHA_N_LOG2 = 2,
    parameter logic [23:0] BLANK_COLOR  = 24'h000000
) (
    input  logic                          vclock,
    input  logic                          reset,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          hsync,
    input  logic                          vsync,
    input  logic                          blank,
    input  logic [23:0]                   bg_pixel,
    input  logic [1:0]                    scale_shift,
    vga_object_compositor_if.slave        upd,
    output logic                          phsync,
    output logic                          pvsync,
    output logic                          pblank,
    output logic [23:0]                   pixel
);
    localparam int unsigned IDX_W   = $clog2(NUM_OBJ + 1);
    localparam int unsigned EXT_W   = COORD_W + 1;
    localparam int unsigned SUM_W   = 8 + ALPHA_N_LOG2;
    localparam int unsigned ALPHA_C = (1 << ALPHA_N_LOG2) - ALPHA_M;

    logic signed [COORD_W-1:0] sh_x [NUM_OBJ];
    logic signed [COORD_W-1:0] sh_y [NUM_OBJ];
    logic [23:0]               sh_color [NUM_OBJ];
    logic [NUM_OBJ-1:0]        sh_en;
    logic signed [COORD_W-1:0] act_x [NUM_OBJ];
    logic signed [COORD_W-1:0] act_y [NUM_OBJ];
    logic [23:0]               act_color [NUM_OBJ];
    logic [NUM_OBJ-1:0]        act_en;

    logic vsync_q, commit_q, ready_q, accept_c;

    assign upd.upd_ready = ready_q;
    assign accept_c      = upd.upd_valid & ready_q;

    // Commit is taken one cycle after the falling edge; ready drops for that cycle only
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            vsync_q  <= 1'b1;
            commit_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            commit_q <= vsync_q & ~vsync;
            ready_q  <= ~(vsync_q & ~vsync);
        end
    end

    // Shadow writes and frame commit into the active set
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            sh_en  <= '0;
            act_en <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x[i]      <= '0;
                sh_y[i]      <= '0;
                sh_color[i]  <= '0;
                act_x[i]     <= '0;
                act_y[i]     <= '0;
                act_color[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (accept_c && upd.upd_index == IDX_W'(i)) begin
                    sh_x[i]     <= upd.upd_x;
                    sh_y[i]     <= upd.upd_y;
                    sh_color[i] <= upd.upd_color;
                    sh_en[i]    <= upd.upd_enable;
                end
                if (commit_q) begin
                    act_x[i]     <= COORD_W'(sh_x[i] <<< scale_shift);
                    act_y[i]     <= COORD_W'((sh_y[i] <<< scale_shift) + COORD_W'(Y_OFFSET));
                    act_color[i] <= sh_color[i];
                    act_en[i]    <= sh_en[i];
                end
            end
        end
    end

    // Half-open span test, widened by one bit so the bounds cannot wrap
    function automatic logic in_span(input logic signed [COORD_W-1:0] p,
                                     input logic signed [COORD_W-1:0] c,
                                     input int unsigned size);
        logic signed [EXT_W-1:0] pe, ce, h;
        pe = {p[COORD_W-1], p};
        ce = {c[COORD_W-1], c};
        h  = EXT_W'(size / 2);
        return (pe >= ce - h) && (pe < ce + h);
    endfunction

    logic signed [COORD_W-1:0] x1, y1;
    logic [23:0]               bg1, bg2, bg3, c1_3, c2_3;
    logic                      hs1, vs1, bl1, hs2, vs2, bl2, hs3, vs3, bl3;
    logic [NUM_OBJ-1:0]        hit_c, hit2;
    logic [23:0]               c1_c, c2_c, blend_c;
    logic [1:0]                n_c, n3;
    logic [SUM_W-1:0]          sum_c;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            hit_c[i] = act_en[i] & in_span(x1, act_x[i], OBJ_W) & in_span(y1, act_y[i], OBJ_H);
    end

    // Two highest-priority hits; the count saturates at two
    always_comb begin
        c1_c = '0;
        c2_c = '0;
        n_c  = 2'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (hit2[i]) begin
                if (n_c == 2'd0) begin
                    c1_c = act_color[i];
                    n_c  = 2'd1;
                end else if (n_c == 2'd1) begin
                    c2_c = act_color[i];
                    n_c  = 2'd2;
                end
            end
        end
    end

    always_comb begin
        blend_c = '0;
        sum_c   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum_c = SUM_W'(ALPHA_M) * SUM_W'(c1_3[ch*8 +: 8])
                  + SUM_W'(ALPHA_C) * SUM_W'(c2_3[ch*8 +: 8]);
            blend_c[ch*8 +: 8] = 8'(sum_c >> ALPHA_N_LOG2);
        end
    end

    // Four-stage pixel pipeline; syncs and blank travel alongside
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            x1 <= '0; y1 <= '0; bg1 <= '0; hs1 <= 1'b1; vs1 <= 1'b1; bl1 <= 1'b1;
            hit2 <= '0; bg2 <= '0; hs2 <= 1'b1; vs2 <= 1'b1; bl2 <= 1'b1;
            c1_3 <= '0; c2_3 <= '0; n3 <= 2'd0; bg3 <= '0;
            hs3 <= 1'b1; vs3 <= 1'b1; bl3 <= 1'b1;
            pixel <= '0; phsync <= 1'b1; pvsync <= 1'b1; pblank <= 1'b1;
        end else begin
            x1  <= COORD_W'(hcount) - COORD_W'(TOTAL_WIDTH / 2);
            y1  <= COORD_W'(TOTAL_HEIGHT) - COORD_W'(vcount);
            bg1 <= bg_pixel; hs1 <= hsync; vs1 <= vsync; bl1 <= blank;

            hit2 <= hit_c; bg2 <= bg1; hs2 <= hs1; vs2 <= vs1; bl2 <= bl1;

            c1_3 <= c1_c; c2_3 <= c2_c; n3 <= n_c; bg3 <= bg2;
            hs3 <= hs2; vs3 <= vs2; bl3 <= bl2;

            if (bl3)                pixel <= BLANK_COLOR;
            else if (n3 == 2'd0)    pixel <= bg3;
            else if (n3 == 2'd1)    pixel <= c1_3;
            else                    pixel <= blend_c;
            phsync <= hs3; pvsync <= vs3; pblank <= bl3;
        end
    end
endmodule

// File: tb/tb_vga_object_compositor.sv
// Directed bench for vga_object_compositor: commit timing, hit bounds, blending,
// handshake stall, dropped index, coordinate wrap and asynchronous reset.
module tb_vga_object_compositor;
    localparam int unsigned NUM_OBJ = 4;
    localparam int unsigned COORD_W = 12;
    localparam logic [23:0] BG      = 24'h123456;

    logic        vclock = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank;
    logic [23:0] bg_pixel;
    logic [1:0]  scale_shift;
    logic        phsync, pvsync, pblank;
    logic [23:0] pixel;

    int n_tests = 0;
    int n_fail  = 0;

    vga_object_compositor_if #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W)) upd_bus ();

    vga_object_compositor #(
        .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .OBJ_W(32), .OBJ_H(16)
    ) dut (
        .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .bg_pixel(bg_pixel),
        .scale_shift(scale_shift), .upd(upd_bus),
        .phsync(phsync), .pvsync(pvsync), .pblank(pblank), .pixel(pixel)
    );

    always #5 vclock = ~vclock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vclock);
        #1;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        hcount = 11'(x + 512);
        vcount = 10'(768 - y);
        repeat (4) tick();
        check(tag, {8'h0, pixel}, {8'h0, exp});
    endtask

    task automatic write_obj(input int idx, input int x, input int y,
                             input logic [23:0] color, input logic en);
        int w;
        upd_bus.upd_index  = 3'(idx);
        upd_bus.upd_x      = 12'(x);
        upd_bus.upd_y      = 12'(y);
        upd_bus.upd_color  = color;
        upd_bus.upd_enable = en;
        upd_bus.upd_valid  = 1'b1;
        w = 0;
        while (!upd_bus.upd_ready && w < 20) begin
            tick();
            w++;
        end
        check("write_ready", {31'h0, upd_bus.upd_ready}, 32'h1);
        tick();
        upd_bus.upd_valid = 1'b0;
    endtask

    task automatic commit_frame();
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        hcount = '0; vcount = '0;
        hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
        bg_pixel = BG; scale_shift = 2'd1;
        upd_bus.upd_valid = 1'b0; upd_bus.upd_index = '0;
        upd_bus.upd_x = '0; upd_bus.upd_y = '0;
        upd_bus.upd_color = '0; upd_bus.upd_enable = 1'b0;
        #2;
        check("rst_pixel",  {8'h0, pixel}, 32'h0);
        check("rst_pblank", {31'h0, pblank}, 32'h1);
        check("rst_phsync", {31'h0, phsync}, 32'h1);
        check("rst_ready",  {31'h0, upd_bus.upd_ready}, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("ready_after_rst", {31'h0, upd_bus.upd_ready}, 32'h1);

        // Background pass-through and 4-cycle sync alignment
        probe("bg_pass", 0, 0, BG);
        hsync = 1'b0; vsync = 1'b0; blank = 1'b1;
        repeat (3) tick();
        check("phsync_d3", {31'h0, phsync}, 32'h1);
        check("pvsync_d3", {31'h0, pvsync}, 32'h1);
        check("pblank_d3", {31'h0, pblank}, 32'h0);
        tick();
        check("phsync_d4", {31'h0, phsync}, 32'h0);
        check("pvsync_d4", {31'h0, pvsync}, 32'h0);
        check("pblank_d4", {31'h0, pblank}, 32'h1);
        check("blank_px",  {8'h0, pixel}, 32'h0);
        hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
        repeat (4) tick();

        // Single red object, visible only after commit
        write_obj(0, 10, 0, 24'hFF0000, 1'b1);
        probe("pre_commit", 20, 256, BG);
        commit_frame();
        probe("red_l_in",  4,   256, 24'hFF0000);
        probe("red_l_out", 3,   256, BG);
        probe("red_r_in",  35,  256, 24'hFF0000);
        probe("red_r_out", 36,  256, BG);
        probe("red_b_in",  20,  248, 24'hFF0000);
        probe("red_b_out", 20,  247, BG);
        probe("red_t_in",  20,  263, 24'hFF0000);
        probe("red_t_out", 20,  264, BG);

        // Two-object blend, then idx1 alone
        write_obj(1, 10, 0, 24'h00FF00, 1'b1);
        commit_frame();
        probe("blend_rg", 20, 256, 24'h7F7F00);
        blank = 1'b1;
        probe("blend_blank", 20, 256, 24'h000000);
        blank = 1'b0;
        write_obj(0, 10, 0, 24'hFF0000, 1'b0);
        commit_frame();
        probe("green_only", 20, 256, 24'h00FF00);

        // Three overlapping: idx1 over idx2, idx3 ignored
        write_obj(2, 10, 0, 24'h0000FF, 1'b1);
        write_obj(3, 10, 0, 24'hFFFFFF, 1'b1);
        commit_frame();
        probe("three_ovl", 20, 256, 24'h007F7F);

        // Update presented in the commit cycle stalls one clock
        vsync = 1'b0;
        check("ready_pre_commit", {31'h0, upd_bus.upd_ready}, 32'h1);
        tick();
        check("ready_commit", {31'h0, upd_bus.upd_ready}, 32'h0);
        upd_bus.upd_index = 3'd0; upd_bus.upd_x = 12'(-100); upd_bus.upd_y = 12'd0;
        upd_bus.upd_color = 24'hFF0000; upd_bus.upd_enable = 1'b1;
        upd_bus.upd_valid = 1'b1;
        tick();
        check("ready_back", {31'h0, upd_bus.upd_ready}, 32'h1);
        tick();
        upd_bus.upd_valid = 1'b0;
        vsync = 1'b1;
        probe("stall_hidden", -200, 256, BG);
        commit_frame();
        probe("stall_visible", -200, 256, 24'hFF0000);

        // Out-of-range index is dropped
        write_obj(4, -100, 0, 24'h0000FF, 1'b0);
        commit_frame();
        probe("drop_obj0", -200, 256, 24'hFF0000);
        probe("drop_ovl",  20,   256, 24'h007F7F);

        // x=2047 scaled by 2 wraps to -2
        write_obj(0, 2047, 10, 24'hFF0000, 1'b1);
        commit_frame();
        probe("wrap_l_in",  -18, 276, 24'hFF0000);
        probe("wrap_l_out", -19, 276, BG);
        probe("wrap_r_in",  13,  276, 24'hFF0000);
        probe("wrap_r_out", 14,  276, BG);
        probe("wrap_old",   -200, 256, BG);

        // Asynchronous reset mid-line
        probe("pre_reset", -18, 276, 24'hFF0000);
        #2 reset = 1'b1;
        #1;
        check("midrst_pixel",  {8'h0, pixel}, 32'h0);
        check("midrst_pblank", {31'h0, pblank}, 32'h1);
        check("midrst_ready",  {31'h0, upd_bus.upd_ready}, 32'h0);
        tick();
        reset = 1'b0;
        probe("post_reset", -18, 276, BG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
